// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_pkg.sv
// Shared types and constants for the synchronizer/deglitch filter cell.
package gf180mcu_fd_sc_mcu9t5v0__sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } filt_state_e;

  // 4 bits covers counts up to FILT_MAX-1 = 14
  localparam int CNT_W    = 4;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 15;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_chain.sv
// SYNC_STAGES-deep flop chain that brings an asynchronous level into CLK.
module gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [SYNC_STAGES-1:0] stg_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stg_q <= {SYNC_STAGES{RST_VAL}};
    else     stg_q <= {stg_q[SYNC_STAGES-2:0], D};
  end

  assign Q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_filt_3.sv
// Synchronizer plus consecutive-cycle deglitch filter driving Z from a flop.
// Define GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN to add registered ZR/ZF edge pulses.
module gf180mcu_fd_sc_mcu9t5v0__sync_filt_3
  import gf180mcu_fd_sc_mcu9t5v0__sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic Z,
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
  output logic ZR,
  output logic ZF,
`endif
  inout  wire  VDD,
  inout  wire  VSS
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end
  if (FILT_CYCLES < FILT_MIN || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
    $error("FILT_CYCLES out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  wire unused_supply = VDD ^ VSS;

  logic             syn;
  filt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;

  gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (RST_VAL)
  ) u_chain (
    .CLK(CLK),
    .RST(RST),
    .D  (I),
    .Q  (syn)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (syn != z_q) begin
          if (FILT_CYCLES == 1) begin
            z_d = syn;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (syn != z_q) begin
          if (cnt_q == CNT_LAST) begin
            z_d     = syn;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // difference vanished before the count completed: glitch
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= RST_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign Z = z_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
  logic zr_q, zf_q;

  // pulses land on the same edge that updates Z
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zr_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      zr_q <= z_d & ~z_q;
      zf_q <= ~z_d & z_q;
    end
  end

  assign ZR = zr_q;
  assign ZF = zf_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_filt_3.sv
// Scoreboard bench: three filter configurations, expected Z transitions queued by stimulus.
module tb_gf180mcu_fd_sc_mcu9t5v0__sync_filt_3;
  import gf180mcu_fd_sc_mcu9t5v0__sync_pkg::*;

  typedef struct {
    int   cyc;
    logic z;
  } ev_t;

  logic clk;
  logic ra, rb, rc, ia, ib, ic;
  logic za, zb, zc;
  logic zra, zfa, zrb, zfb, zrc, zfc;
  logic pa, pb, pc;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  ev_t qa[$], qb[$], qc[$];
  int  n_chk = 0, n_fail = 0;
  int  edge_n = 0;
  int  base;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // A: defaults
  gf180mcu_fd_sc_mcu9t5v0__sync_filt_3 dut_a (
    .CLK(clk), .RST(ra), .I(ia), .Z(za),
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
    .ZR(zra), .ZF(zfa),
`endif
    .VDD(vdd), .VSS(vss)
  );

  // B: fast filter, deeper synchronizer
  gf180mcu_fd_sc_mcu9t5v0__sync_filt_3 #(.SYNC_STAGES(3), .FILT_CYCLES(1)) dut_b (
    .CLK(clk), .RST(rb), .I(ib), .Z(zb),
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
    .ZR(zrb), .ZF(zfb),
`endif
    .VDD(vdd), .VSS(vss)
  );

  // C: reset value 1
  gf180mcu_fd_sc_mcu9t5v0__sync_filt_3 #(.RST_VAL(1'b1)) dut_c (
    .CLK(clk), .RST(rc), .I(ic), .Z(zc),
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
    .ZR(zrc), .ZF(zfc),
`endif
    .VDD(vdd), .VSS(vss)
  );

`ifndef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
  assign {zra, zfa, zrb, zfb, zrc, zfc} = '0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic mon(input int id, input logic z, input logic rst, input logic rv,
                     input logic zr, input logic zf, inout logic prev);
    ev_t e;
    bit  have;
    if (rst) begin
      check($sformatf("rst_z_%0d", id), z, rv);
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
      check($sformatf("rst_zr_%0d", id), zr, 0);
      check($sformatf("rst_zf_%0d", id), zf, 0);
`endif
    end else begin
      if (z !== prev) begin
        have = 0;
        case (id)
          0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1; end
          1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1; end
          default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1; end
        endcase
        if (!have) check($sformatf("unexpected_z_%0d", id), z, prev);
        else begin
          check($sformatf("z_edge_%0d", id), edge_n, e.cyc);
          check($sformatf("z_val_%0d", id), z, e.z);
        end
      end
`ifdef GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN
      check($sformatf("zr_%0d", id), zr, z & ~prev);
      check($sformatf("zf_%0d", id), zf, ~z & prev);
`endif
    end
    prev = z;
  endtask

  always @(negedge clk) begin
    mon(0, za, ra, 1'b0, zra, zfa, pa);
    mon(1, zb, rb, 1'b0, zrb, zfb, pb);
    mon(2, zc, rc, 1'b1, zrc, zfc, pc);
  end

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    ia = 1'b0; ib = 1'b0; ic = 1'b1;
    pa = 1'b0; pb = 1'b0; pc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cnt_a", dut_a.cnt_q, 0);
    check("rst_state_a", dut_a.state_q, IDLE);
    step_n(1);
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    step_n(3);

    // 3-cycle pulse on syn is rejected
    ia = 1'b1; step_n(3);
    ia = 1'b0; step_n(8);
    check("glitch_cnt_a", dut_a.cnt_q, 0);
    check("glitch_state_a", dut_a.state_q, IDLE);

    // rise: Z at edge 6
    base = edge_n; ia = 1'b1; qa.push_back('{base + 6, 1'b1}); step_n(10);
    // fall
    base = edge_n; ia = 1'b0; qa.push_back('{base + 6, 1'b0}); step_n(10);

    // reset during the third counting cycle, then full latency after release
    ia = 1'b1; step_n(5);
    ra = 1'b1; step_n(1);
    check("midrst_cnt_a", dut_a.cnt_q, 0);
    step_n(2);
    base = edge_n; ra = 1'b0; qa.push_back('{base + 6, 1'b1}); step_n(10);

    // 2-cycle alternation never reaches the filter length
    for (int k = 0; k < 10; k++) begin
      ia = 1'b0; step_n(2);
      ia = 1'b1; step_n(2);
    end
    step_n(8);

    // B: FILT_CYCLES=1, SYNC_STAGES=3 -> Z at edge 4
    base = edge_n; ib = 1'b1; qb.push_back('{base + 4, 1'b1}); step_n(8);
    base = edge_n; ib = 1'b0; qb.push_back('{base + 4, 1'b0}); step_n(8);
    // single-cycle pulse passes straight through, back-to-back updates
    base = edge_n; ib = 1'b1; step_n(1); ib = 1'b0;
    qb.push_back('{base + 4, 1'b1});
    qb.push_back('{base + 5, 1'b0});
    step_n(8);

    // C: has sat at reset value 1 with I=1 for well over 20 cycles; now fall
    base = edge_n; ic = 1'b0; qc.push_back('{base + 6, 1'b0}); step_n(10);

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__sync_filt_3.md
GF180MCU_FD_SC_MCU9T5V0__SYNC_FILT_3 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__sync_filt_3

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on I; legal range 2..4.
REQ-002 Parameter FILT_CYCLES, default 4: consecutive cycles the synchronized input must differ from Z before Z toggles; legal range 1..15.
REQ-003 Parameter RST_VAL, default 1'b0: value loaded into every synchronizer stage and into Z during reset.
REQ-004 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port RST, input, 1: asynchronous, active-high reset.
REQ-006 Port I, input, 1: asynchronous level from a buffered net, such as a buf-driven pad or long route.
REQ-007 Port Z, output, 1: synchronized, deglitched copy of I, driven directly from a flop.
REQ-008 Ports VDD and VSS, inout, 1 each: supply pins; no functional effect.
REQ-009 Ports ZR and ZF, output, 1 each, exist only with the Configuration macro: rise-event and fall-event pulses.

Function
REQ-010 I SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "syn".
REQ-011 The filter SHALL have two states: IDLE, meaning syn equals Z, and PEND, meaning syn differs from Z and is being counted.
REQ-012 In IDLE, at a rising edge where syn differs from Z: if FILT_CYCLES is 1, Z <= syn and the state stays IDLE; otherwise cnt <= 1 and the state moves to PEND.
REQ-013 In PEND, at a rising edge where syn still differs from Z: if cnt equals FILT_CYCLES-1, Z <= syn, cnt <= 0 and the state moves to IDLE; otherwise cnt increments.
REQ-014 In PEND, at a rising edge where syn equals Z, a glitch is rejected: cnt <= 0, the state moves to IDLE, and Z is unchanged.
REQ-015 Latency: a level change on I that meets setup before edge 1 SHALL appear on Z at edge SYNC_STAGES+FILT_CYCLES, which is edge 6 with the defaults.
REQ-016 A pulse on syn shorter than FILT_CYCLES cycles SHALL never change Z.
REQ-017 cnt SHALL never exceed FILT_CYCLES-1; no wrap-around is reachable.
REQ-018 When syn changes in the same cycle that Z updates, the new difference SHALL start a fresh count from the following edge.

Reset
REQ-019 While RST is high: all sync stages and Z SHALL equal RST_VAL, cnt SHALL be 0, the state SHALL be IDLE, and ZR and ZF (if present) SHALL be 0.
REQ-020 Reset asserted mid-count SHALL abort the pending count immediately, with no Z toggle.
REQ-021 After RST falls with I differing from RST_VAL, Z SHALL follow only after the full SYNC_STAGES+FILT_CYCLES latency, and no ZR or ZF pulse SHALL be issued for the reset value itself.

Configuration
REQ-022 With macro GF180MCU_FD_SC_MCU9T5V0_SYNC_EDGE_EN defined:
- ZR SHALL be high for exactly one cycle, registered, on the same edge at which Z goes 0->1.
- ZF SHALL behave the same way for Z going 1->0.
REQ-023 Without the macro, ports ZR and ZF and their flops SHALL not exist; Z behaviour is identical.

Structure
REQ-024 Package gf180mcu_fd_sc_mcu9t5v0__sync_pkg SHALL hold:
- the filter state enum (IDLE, PEND);
- the counter width constant, 4 bits, sufficient for FILT_CYCLES up to 15;
- the legal-range constants for SYNC_STAGES and FILT_CYCLES.
REQ-025 The synchronizer chain SHALL be the sub-module gf180mcu_fd_sc_mcu9t5v0__sync_chain, parameterized by SYNC_STAGES and RST_VAL, with ports CLK, RST, D and Q.
REQ-026 Out-of-range parameters SHALL be flagged by an elaboration-time check.

Verification
REQ-027 Defaults, reset released with I=0; I rises before edge 1 -> Z=1 at edge 6; ZR=1 for that one cycle only, with the macro defined.
REQ-028 Defaults, Z=0; a 3-cycle high pulse on syn -> Z stays 0, cnt returns to 0, and no ZR pulse occurs.
REQ-029 Defaults; RST asserted at the third cycle of a count -> Z=RST_VAL immediately; after release with I held at 1, Z=1 six edges later.
REQ-030 FILT_CYCLES=1, SYNC_STAGES=3; I toggles 1->0 -> Z=0 at edge 4 and ZF pulses for one cycle.
REQ-031 RST_VAL=1, reset released with I=1 -> Z stays 1 and no ZR or ZF pulse occurs for 20 cycles.
REQ-032 Defaults; I alternates every 2 cycles for 40 cycles -> Z never changes.
